rr_slice_arbiter: RTL
=====================

Name: rr_slice_arbiter

Overview:
- Round-robin, time-sliced arbiter that shares one resource among N requesters.
- Each grant is capped at SLICE cycles. An internal slice counter (period SLICE, same behaviour as the team's modulo counter) times the grant.
- Sits in front of any shared datapath or bus. Consumers gate on gnt/gnt_id; slice_end warns of forced handover.

Parameters:
- N, 4, number of requesters; N >= 2.
- SLICE, 8, maximum consecutive grant cycles per holder; SLICE >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- r  input  1  reset, asynchronous, active-high.
- req  input  N  request vector; bit i high = requester i wants the resource.
- gnt  output  N  one-hot grant; all-zero when idle; registered.
- gnt_valid  output  1  high when any gnt bit is high; registered.
- gnt_id  output  $clog2(N)  index of current holder; 0 when idle; registered.
- slice_end  output  1  high in the last cycle of a full slice; registered.

Behaviour:
- Reset (r=1, asynchronous, takes effect immediately without a clock edge):
  - gnt=0, gnt_valid=0, gnt_id=0, slice_end=0.
  - slice count cnt=0, search pointer ptr=0, state IDLE.
- State IDLE (gnt_valid=0):
  - At each edge, if req != 0, select the first set bit scanning ptr, ptr+1, ... with wrap mod N.
  - Register the grant: gnt one-hot, gnt_id, gnt_valid=1, cnt=0, ptr=(winner+1) mod N, state GRANT.
  - Latency is 1 cycle: req sampled in cycle k gives gnt in cycle k+1.
- State GRANT:
  - cnt increments by 1 each granted cycle. Width max(1,$clog2(SLICE)). cnt never exceeds SLICE-1.
  - slice_end = gnt_valid && cnt==SLICE-1. Register it so it aligns with that cycle; do not add a combinational path from req.
  - End condition, evaluated at each edge: req[gnt_id]==0 (release) OR cnt==SLICE-1 (expiry).
  - On end, re-arbitrate in the same edge from ptr over the current req. Handover has zero bubble:
    - New winner: reload cnt=0, update ptr, stay in GRANT.
    - No requester set: clear gnt/gnt_valid/gnt_id, state IDLE.
  - On expiry with the holder still requesting, the holder is scanned last (ptr = holder+1). It regains the grant only if no other bit is set, and then starts a fresh slice with cnt=0.
  - Release and expiry in the same cycle: treat as release; slice_end still pulses in that cycle.
  - Non-holder req changes during GRANT have no effect until the next end condition. There is no preemption.
- SLICE==1:
  - Every granted cycle is an expiry cycle, so re-arbitration happens every edge.
  - slice_end is high whenever gnt_valid is high.
  - Implement cnt as a constant 0; no counter flops are required.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt == (gnt_valid << gnt_id).
  - A continuously requesting requester is granted within (N-1)*SLICE+1 cycles of its request being sampled.
- Reset mid-grant: all outputs clear immediately. After r falls, arbitration resumes from ptr=0 at the first edge.

Test Plan (N=4, SLICE=4 unless stated; cycle 0 = first cycle after reset release):
- Assert r asynchronously between edges during GRANT -> gnt=0000, gnt_valid=0, gnt_id=0, slice_end=0 before the next edge. Then release r with req=1010 -> gnt=0010, gnt_id=1 in cycle 1.
- req=0100 held from cycle 0 -> gnt=0100 cycles 1-4, slice_end high only in cycle 4. gnt stays 0100 in cycle 5 with a new slice; slice_end next in cycle 8.
- req=1111 held -> gnt 0001 (c1-4), 0010 (c5-8), 0100 (c9-12), 1000 (c13-16), 0001 (c17). slice_end in c4, 8, 12, 16. No idle cycles.
- req=0011 from cycle 0, req[0] drops in cycle 2 -> gnt 0001 in c1-2, 0010 from c3 with cnt reloaded. slice_end first in c6, never while req[0] holds the grant.
- req=0001 from cycle 0, dropped in cycle 3 -> gnt=0001 c1-3, then gnt=0000, gnt_valid=0 from c4. Reassert req=1000 in c6 -> gnt=1000 in c7.
- SLICE=1, req=0101 held -> gnt alternates 0001, 0100 every cycle from c1. slice_end high every granted cycle.

Source files
------------

// File: rtl/rr_slice_arbiter.sv
// Round-robin, time-sliced arbiter. One holder at a time; each grant lasts
// at most SLICE cycles. On release or slice expiry the next winner is picked
// in the same edge (zero-bubble handover), scanning from the search pointer.
module rr_slice_arbiter #(
  parameter int N     = 4,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 slice_end
);
  localparam int IW = $clog2(N);
  localparam int CW = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLICE - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_d;
  logic            vld_d;
  logic [IW-1:0]   gid_d;
  logic            se_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win;
  logic            found;
  logic            arb;

  // First set request bit, scanning ptr, ptr+1, ... with wrap
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Next state: re-arbitrate when idle, on release or on slice expiry
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    vld_d   = gnt_valid;
    gid_d   = gnt_id;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    arb     = (state_q == IDLE) || !req[gnt_id] || (cnt_q == CNT_LAST);
    if (arb) begin
      if (found) begin
        state_d    = GRANT;
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        vld_d      = 1'b1;
        gid_d      = win;
        cnt_d      = '0;
        ptr_d      = (int'(win) == N - 1) ? '0 : win + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
        gid_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered so it lines up with the last cycle of the new state
    se_d = vld_d && (cnt_d == CNT_LAST);
  end

  // Grant, pointer and FSM state registers
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q   <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      slice_end <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      gnt_valid <= vld_d;
      gnt_id    <= gid_d;
      slice_end <= se_d;
      ptr_q     <= ptr_d;
    end
  end

  // Slice counter; with a single-cycle slice every granted cycle is the last
  generate
    if (SLICE > 1) begin : g_cnt
      // Cycles spent in the current slice
      always_ff @(posedge clk or posedge r) begin
        if (r) cnt_q <= '0;
        else   cnt_q <= cnt_d;
      end
    end else begin : g_nocnt
      assign cnt_q = '0;
    end
  endgenerate

endmodule
